// File: rtl/approx_seq_div_16_8.sv
// ============================================================================
// approx_seq_div_16_8 : radix-2 restoring divider, one quotient bit per cycle.
// Optional macro DIV_APPROX_EN skips the APPROX_K low-order iterations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module approx_seq_div_16_8 #(
  parameter int DW       = 16,
  parameter int VW       = 8,
  parameter int APPROX_K = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

`ifdef DIV_APPROX_EN
  localparam int STEPS = DW - APPROX_K;
`else
  localparam int STEPS = DW;
`endif
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] work_q, work_d;        // dividend bits shifting out, quotient bits shifting in
  logic [VW-1:0] divisor_q, divisor_d;
  logic [VW:0]   pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   pr_shift;
  logic          pr_ge;
  logic [VW:0]   pr_next;
  logic [DW-1:0] work_next;

  always_comb begin
    pr_shift  = {pr_q[VW-1:0], work_q[DW-1]};
    pr_ge     = (pr_shift >= {1'b0, divisor_q});
    pr_next   = pr_ge ? (pr_shift - {1'b0, divisor_q}) : pr_shift;
    work_next = {work_q[DW-2:0], pr_ge};

    state_d     = state_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            // No iterations needed; the result is fixed by the operands alone.
            quotient_d  = '1;
            remainder_d = dividend[VW-1:0];
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            work_d    = dividend;
            divisor_d = divisor;
            pr_d      = '0;
            cnt_d     = '0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        pr_d   = pr_next;
        work_d = work_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          dbz_d   = 1'b0;
          state_d = DONE;
`ifdef DIV_APPROX_EN
          quotient_d  = work_next << APPROX_K;
          remainder_d = '0;
`else
          quotient_d  = work_next;
          remainder_d = pr_next[VW-1:0];
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      divisor_q   <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      divisor_q   <= divisor_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_approx_seq_div_16_8.sv
// ============================================================================
// tb_approx_seq_div_16_8 : self-checking bench for approx_seq_div_16_8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_approx_seq_div_16_8;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int K  = 4;
`ifdef DIV_APPROX_EN
  localparam int EXP_LAT = DW - K + 1;
`else
  localparam int EXP_LAT = DW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  approx_seq_div_16_8 #(.DW(DW), .VW(VW), .APPROX_K(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncated low bits in approximate mode.
  function automatic void model(input int a, input int b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic z);
    if (b == 0) begin
      q = '1;
      r = a[VW-1:0];
      z = 1'b1;
    end else begin
`ifdef DIV_APPROX_EN
      q = DW'((a / b) & ~((1 << K) - 1));
      r = '0;
`else
      q = DW'(a / b);
      r = VW'(a % b);
`endif
      z = 1'b0;
    end
  endfunction

  task automatic run_op(input int a, input int b,
                        output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic z, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    dividend = DW'(a);
    divisor  = VW'(b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h z=%b, want 1 0 0000 00 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_directed();
    int a_tab[5] = '{1000, 'hFFFF, 'hFFFF, 5, 200};
    int b_tab[5] = '{7, 'hFF, 1, 9, 3};
    logic [DW-1:0] q, eq;
    logic [VW-1:0] r, er;
    logic z, ez;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(a_tab[i], b_tab[i], q, r, z, lat);
      model(a_tab[i], b_tab[i], eq, er, ez);
      checks++;
      if (q !== eq) begin errors++; $display("FAIL directed%0d quotient: got %h want %h", i, q, eq); end
      checks++;
      if (r !== er) begin errors++; $display("FAIL directed%0d remainder: got %h want %h", i, r, er); end
      checks++;
      if (z !== ez) begin errors++; $display("FAIL directed%0d div_by_zero: got %b want %b", i, z, ez); end
      checks++;
      if (lat != EXP_LAT) begin errors++; $display("FAIL directed%0d latency: got %0d want %0d", i, lat, EXP_LAT); end
      release_result();
    end
    // Spec constants for 1000/7 independent of the model
    run_op(1000, 7, q, r, z, lat);
    checks++;
`ifdef DIV_APPROX_EN
    if ({q, r} !== {16'h0080, 8'h00}) begin errors++; $display("FAIL const_1000_7: got %h/%h want 0080/00", q, r); end
`else
    if ({q, r} !== {16'h008E, 8'h06}) begin errors++; $display("FAIL const_1000_7: got %h/%h want 008e/06", q, r); end
`endif
    release_result();
  endtask

  task automatic test_div_by_zero();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic z;
    int lat;
    run_op('h04D2, 0, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {16'hFFFF, 8'hD2, 1'b1}) begin
      errors++;
      $display("FAIL div_by_zero: got q=%h r=%h z=%b want ffff d2 1", q, r, z);
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL div_by_zero latency: got %0d want 1", lat); end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] q, eq;
    logic [VW-1:0] r, er;
    logic z, ez;
    int lat;
    int bad;
    run_op(50000, 123, q, r, z, lat);
    model(50000, 123, eq, er, ez);
    bad = 0;
    dividend = 16'h1234;
    divisor  = 8'h00;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, eq, er, ez}) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL backpressure stability: %0d bad cycles, want 0", bad); end
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL backpressure hold: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL no_bypass: in_ready=%b during handshake want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, eq, er}) begin
      errors++;
      $display("FAIL after_release: in_ready=%b out_valid=%b q=%h r=%h want 1 0 %h %h",
               in_ready, out_valid, quotient, remainder, eq, er);
    end
    run_op(777, 5, q, r, z, lat);
    model(777, 5, eq, er, ez);
    checks++;
    if ({q, r, z} !== {eq, er, ez}) begin
      errors++; $display("FAIL post_backpressure op: got %h %h %b want %h %h %b", q, r, z, eq, er, ez);
    end
    release_result();
  endtask

  task automatic test_reset_midop();
    logic [DW-1:0] q, eq;
    logic [VW-1:0] r, er;
    logic z, ez;
    int lat;
    int stale;
    dividend = 16'd1000;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midop: in_ready=%b out_valid=%b q=%h r=%h z=%b want 1 0 0000 00 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    stale = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL stale_result: out_valid seen %0d cycles want 0", stale); end
    run_op(200, 3, q, r, z, lat);
    model(200, 3, eq, er, ez);
    checks++;
    if ({q, r, z} !== {eq, er, ez}) begin
      errors++; $display("FAIL after_reset 200/3: got %h %h %b want %h %h %b", q, r, z, eq, er, ez);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] q, eq;
    logic [VW-1:0] r, er;
    logic z, ez;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(4000 + i * 1111, 13 + i, q, r, z, lat);
      model(4000 + i * 1111, 13 + i, eq, er, ez);
      checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
        errors++; $display("FAIL back_to_back%0d: got %h %h %b want %h %h %b", i, q, r, z, eq, er, ez);
      end
      release_result();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
        errors++; $display("FAIL back_to_back%0d idle: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q, eq;
    logic [VW-1:0] r, er;
    logic z, ez;
    int lat;
    int a, b;
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 65535));
      b = (i % 10 == 9) ? 0 : int'($urandom_range(1, 255));
      run_op(a, b, q, r, z, lat);
      model(a, b, eq, er, ez);
      checks++;
      if ({q, r, z} !== {eq, er, ez}) begin
        errors++; $display("FAIL random %0d/%0d: got %h %h %b want %h %h %b", a, b, q, r, z, eq, er, ez);
      end
      checks++;
      if (lat != ((b == 0) ? 1 : EXP_LAT)) begin
        errors++; $display("FAIL random latency %0d/%0d: got %0d", a, b, lat);
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
